spi_block_sequencer: RTL and testbench
======================================

Name: spi_block_sequencer

Overview:
- Sits directly upstream of the SPI byte master. Bridges the AES datapath's 128-bit blocks to the master's 8-bit start/tx/rx/done interface.
- Accepts one 128-bit block and runs NBYTES back-to-back byte transfers through the master, MSB byte first.
- Assembles the received bytes into a 128-bit response block, returned over a valid/ready handshake.
- Includes an inter-byte gap and a per-byte completion timeout.

Parameters:
- NBYTES, 16, bytes per block; block width = 8*NBYTES.
- GAP_CYCLES, 2, idle clk cycles between a byte completion and the next spi_start; 0 allowed.
- TIMEOUT_CYCLES, 1024, max clk cycles to wait for a byte completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- blk_valid  in  1  upstream block present.
- blk_ready  out  1  sequencer can accept a block.
- blk_tx  in  8*NBYTES  block to transmit; byte 0 = bits [8*NBYTES-1 -: 8].
- rsp_valid  out  1  response block available.
- rsp_ready  in  1  downstream accepts response.
- rsp_rx  out  8*NBYTES  received block, same byte order as blk_tx.
- rsp_err  out  1  response ended by timeout.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_tx  out  8  byte to the SPI master.
- spi_rx  in  8  byte from the SPI master, valid when completion is detected.
- spi_done  in  1  SPI master completion level.
- busy  out  1  high in any state other than IDLE.
- byte_idx  out  clog2(NBYTES)  index of the current byte.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; blk_ready = 1.
  - rsp_valid, rsp_err, spi_start, busy, byte_idx, spi_tx, rsp_rx and done_prev all 0.
- done_prev: registered copy of spi_done, updated every cycle.
- Completion event: spi_done==1 && done_prev==0, counted only in WAIT. A done level already high on entry to WAIT is ignored until it falls and rises again.
- FSM states: IDLE, START, WAIT, GAP, RESP.
- IDLE:
  - blk_ready = 1.
  - On blk_valid && blk_ready: latch blk_tx into the shift register, clear the rx register, byte_idx = 0, go to START.
- START:
  - spi_start = 1 for exactly this cycle.
  - spi_tx = current byte; held stable until the completion event.
  - Clear the timeout counter; go to WAIT.
- WAIT: on the completion event:
  - Shift spi_rx into the rx register at byte position byte_idx.
  - If byte_idx == NBYTES-1, go to RESP.
  - Otherwise byte_idx++ and go to GAP, or directly to START if GAP_CYCLES == 0.
- WAIT timeout: timeout counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES (when nonzero) with no completion event, go to RESP with rsp_err = 1. Unreceived bytes stay 0.
- GAP: counts GAP_CYCLES cycles, then goes to START.
- RESP:
  - rsp_valid = 1; rsp_rx and rsp_err held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, clear rsp_err.
  - blk_ready = 0 throughout RESP; there is no block/response overlap.
- Latency:
  - Accept at cycle N gives spi_start at N+1.
  - Last completion at cycle M gives rsp_valid at M+1.
  - Start-to-start spacing = master transfer time + 1 + GAP_CYCLES.
- blk_valid while busy is ignored; it is not queued.
- spi_done high in the same cycle as a timeout expiry: the completion wins.
- Reset mid-block: all outputs return to reset values immediately. Partial rx data is discarded. The SPI master is reset from the same rst_n.

Test Plan:
- Single block: blk_tx = 0x00112233_44556677_8899AABB_CCDDEEFF, loopback model (miso = mosi) → 16 spi_start pulses carrying bytes 0x00..0xFF in order; rsp_rx equals blk_tx; rsp_err = 0.
- Gap check: GAP_CYCLES = 3 → exactly 4 cycles from each completion event to the next spi_start; GAP_CYCLES = 0 → 1 cycle.
- Backpressure: rsp_ready held low 20 cycles → rsp_valid and rsp_rx stable throughout; blk_ready = 0; a blk_valid pulse during this window is not accepted.
- Timeout: master model never asserts done on byte 5 with TIMEOUT_CYCLES = 64 → rsp_valid 65 cycles after that byte's start; rsp_err = 1; bytes 0–4 correct, rest 0.
- Stale done: spi_done held high across a start → no completion counted until it falls and re-rises; byte_idx does not advance early.
- Reset mid-block: assert rst_n low after byte 7 → busy, spi_start, rsp_valid = 0 asynchronously; after release a new block completes correctly.

Source files
------------

// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer
//
// Bridges 128-bit (8*NBYTES) blocks from the AES datapath onto the
// byte-wide start/tx/rx/done interface of the SPI byte master.
// A block is sent MSB byte first, one SPI transfer per byte.
// There is an optional idle gap between transfers.
// The received bytes are assembled into a response block, and that block
// is returned over a valid/ready handshake.
// A per-byte completion timeout ends a block early. In that case the
// response carries rsp_err = 1 and the bytes never received are zero.

module spi_block_sequencer #(
    parameter int NBYTES         = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BW            = 8 * NBYTES,
    localparam int IDX_W         = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,

    // Upstream block interface
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [BW-1:0]    blk_tx,

    // Downstream response interface
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BW-1:0]    rsp_rx,
    output logic             rsp_err,

    // SPI byte master interface
    output logic             spi_start,
    output logic [7:0]       spi_tx,
    input  logic [7:0]       spi_rx,
    input  logic             spi_done,

    // Status
    output logic             busy,
    output logic [IDX_W-1:0] byte_idx
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam bit               GAP_EN   = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             done_prev;
    logic [BW-1:0]    tx_shift;   // bytes still to send, next one in the top byte
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             accept;
    logic             completion;
    logic             tmo_hit;
    logic             gap_end;
    logic             last_byte;
    logic             rsp_take;

    // A completion is a rising edge of spi_done seen while waiting. A level
    // still high from the previous byte is therefore ignored until it falls.
    assign completion = (state == S_WAIT) && spi_done && !done_prev;
    // When the completion and the timeout expiry arrive in the same cycle,
    // the completion wins.
    assign tmo_hit    = TMO_EN && (state == S_WAIT) && !completion && (tmo_cnt == TMO_LAST);
    assign gap_end    = (gap_cnt == GAP_LAST);
    assign last_byte  = (byte_idx == IDX_LAST);
    assign accept     = blk_valid && blk_ready;
    assign rsp_take   = rsp_valid && rsp_ready;

    // State register
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // flop samples values from before the clock edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake/strobe outputs
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        spi_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;

        case (state)
            S_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) begin
                    state_nxt = S_START;
                end
            end

            S_START: begin
                spi_start = 1'b1;
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (completion) begin
                    if (last_byte) begin
                        state_nxt = S_RESP;
                    end else if (GAP_EN) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_START;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end

            S_GAP: begin
                if (gap_end) begin
                    state_nxt = S_START;
                end
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge detector history for spi_done, sampled every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            done_prev <= spi_done;
        end
    end

    // Byte datapath: tx byte selection, rx assembly, byte index and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            spi_tx   <= '0;
            rsp_rx   <= '0;
            byte_idx <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                spi_tx   <= blk_tx[BW-1 -: 8];
                tx_shift <= blk_tx << 8;
                rsp_rx   <= '0;
                byte_idx <= '0;
                rsp_err  <= 1'b0;
            end

            if (completion) begin
                // Byte k of the block lives in bits [BW-1-8k -: 8], the same
                // order as blk_tx, so positions that were never received stay zero.
                for (int k = 0; k < NBYTES; k++) begin
                    if (byte_idx == IDX_W'(k)) begin
                        rsp_rx[8*(NBYTES-1-k) +: 8] <= spi_rx;
                    end
                end
                // spi_tx only changes once the current byte has completed,
                // so the master sees it stable for the whole transfer.
                if (!last_byte) begin
                    byte_idx <= byte_idx + 1'b1;
                    spi_tx   <= tx_shift[BW-1 -: 8];
                    tx_shift <= tx_shift << 8;
                end
            end

            if (tmo_hit) begin
                rsp_err <= 1'b1;
            end else if (rsp_take) begin
                rsp_err <= 1'b0;
            end
        end
    end

    // Inter-byte gap and per-byte timeout counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == S_GAP && !gap_end) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (TMO_EN && state == S_WAIT && tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_block_sequencer.sv
// Testbench for spi_block_sequencer.
// Instance A runs with GAP_CYCLES=3 and TIMEOUT_CYCLES=64. A scoreboard
// checks its SPI bytes, the gap spacing, the latency and the response blocks.
// Instance B runs with GAP_CYCLES=0 and carries loopback blocks only.

module tb_spi_block_sequencer;

    localparam int NB    = 16;
    localparam int BW    = 8 * NB;
    localparam int GAP_A = 3;
    localparam int TMO_A = 64;
    localparam int GAP_B = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A signals
    logic          blk_valid, blk_ready, rsp_valid, rsp_ready, rsp_err;
    logic          spi_start, spi_done, busy;
    logic [BW-1:0] blk_tx, rsp_rx;
    logic [7:0]    spi_tx, spi_rx;
    logic [3:0]    byte_idx;

    // Instance B signals
    logic          b_blk_valid, b_blk_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic          b_spi_start, b_spi_done, b_busy;
    logic [BW-1:0] b_blk_tx, b_rsp_rx;
    logic [7:0]    b_spi_tx, b_spi_rx;
    logic [3:0]    b_byte_idx;

    spi_block_sequencer #(.NBYTES(NB), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TMO_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_tx(blk_tx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rx(rsp_rx), .rsp_err(rsp_err),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_done(spi_done),
        .busy(busy), .byte_idx(byte_idx)
    );

    spi_block_sequencer #(.NBYTES(NB), .GAP_CYCLES(GAP_B)) u_dut_gap0 (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_tx(b_blk_tx),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rx(b_rsp_rx), .rsp_err(b_rsp_err),
        .spi_start(b_spi_start), .spi_tx(b_spi_tx), .spi_rx(b_spi_rx), .spi_done(b_spi_done),
        .busy(b_busy), .byte_idx(b_byte_idx)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard queues and master-model configuration
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         idx;
    } tx_exp_t;

    typedef struct {
        logic [BW-1:0] rx;
        logic          err;
    } rsp_exp_t;

    tx_exp_t       exp_tx_q[$];
    rsp_exp_t      exp_rsp_q[$];
    logic [BW-1:0] b_exp_q[$];

    logic [7:0] m_rx_bytes [NB];
    int         m_hang  = -1;
    bit         m_stale = 1'b0;
    int         m_k     = 0;

    // Reference model: the response block is the received bytes laid out
    // byte 0 first (most significant). Only the first 'got' bytes arrived,
    // so every byte after them is zero.
    function automatic logic [BW-1:0] model_rsp(input logic [7:0] rxb [NB], input int got);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            r = (r << 8) | BW'((k < got) ? rxb[k] : 8'h00);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // SPI master model for instance A
    // ------------------------------------------------------------------
    // After each start the model completes the byte 1..5 cycles later, and
    // it then holds spi_done high until the next start. It can also keep
    // spi_done high for three cycles past a start (stale mode), or never
    // complete one chosen byte (hang).
    int m_wait_left, m_stale_left, m_cur;
    bit m_active, m_hung;

    initial begin : master_a
        spi_done = 1'b0;
        spi_rx   = 8'h00;
        m_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                spi_done = 1'b0;
                m_active = 1'b0;
            end else if (spi_start) begin
                m_cur        = m_k;
                m_k++;
                m_hung       = (m_cur == m_hang);
                m_active     = 1'b1;
                m_wait_left  = $urandom_range(1, 5);
                m_stale_left = m_stale ? 3 : 0;
                if (!m_stale) spi_done = 1'b0;
            end else if (m_active) begin
                if (m_stale_left > 0) begin
                    m_stale_left--;
                    if (m_stale_left == 0) spi_done = 1'b0;
                end else if (!m_hung) begin
                    m_wait_left--;
                    if (m_wait_left == 0) begin
                        spi_rx   = (m_cur < NB) ? m_rx_bytes[m_cur] : 8'hxx;
                        spi_done = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard for instance A
    // ------------------------------------------------------------------
    int            a_cyc = 0, a_last_start = 0, a_last_evt = 0, a_cur_idx = 0;
    bit            a_pending = 0, a_evt_valid = 0, a_rsp_seen = 0, a_stable = 1, a_done_q = 0, a_rise;
    logic [BW-1:0] a_rsp_first;
    logic          a_err_first;
    tx_exp_t       a_te;
    rsp_exp_t      a_re;

    initial begin : monitor_a
        forever begin
            @(negedge clk);
            #1;
            a_cyc++;
            a_rise   = spi_done && !a_done_q;
            a_done_q = spi_done;
            if (!rst_n) begin
                a_pending   = 1'b0;
                a_evt_valid = 1'b0;
                a_rsp_seen  = 1'b0;
            end else begin
                if (spi_start) begin
                    check("start_expected", BW'(exp_tx_q.size() > 0), BW'(1));
                    if (exp_tx_q.size() > 0) begin
                        a_te = exp_tx_q.pop_front();
                        check("spi_tx", BW'(spi_tx), BW'(a_te.data));
                        check("byte_idx_at_start", BW'(byte_idx), BW'(a_te.idx));
                        a_cur_idx = a_te.idx;
                    end
                    if (a_evt_valid) check("gap_spacing", BW'(a_cyc - a_last_evt), BW'(GAP_A + 1));
                    a_evt_valid  = 1'b0;
                    a_pending    = 1'b1;
                    a_last_start = a_cyc;
                end else if (a_pending && a_rise) begin
                    check("byte_idx_at_done", BW'(byte_idx), BW'(a_cur_idx));
                    a_pending   = 1'b0;
                    a_evt_valid = 1'b1;
                    a_last_evt  = a_cyc;
                end

                if (rsp_valid) begin
                    if (!a_rsp_seen) begin
                        a_rsp_seen  = 1'b1;
                        a_stable    = 1'b1;
                        a_rsp_first = rsp_rx;
                        a_err_first = rsp_err;
                        check("blk_ready_in_resp", BW'(blk_ready), BW'(0));
                        if (a_pending) check("timeout_latency", BW'(a_cyc - a_last_start), BW'(TMO_A + 1));
                        else           check("rsp_latency", BW'(a_cyc - a_last_evt), BW'(1));
                        a_pending   = 1'b0;
                        a_evt_valid = 1'b0;
                    end else if (rsp_rx !== a_rsp_first || rsp_err !== a_err_first || blk_ready !== 1'b0) begin
                        a_stable = 1'b0;
                    end
                    if (rsp_ready) begin
                        check("rsp_expected", BW'(exp_rsp_q.size() > 0), BW'(1));
                        if (exp_rsp_q.size() > 0) begin
                            a_re = exp_rsp_q.pop_front();
                            check("rsp_rx", rsp_rx, a_re.rx);
                            check("rsp_err", BW'(rsp_err), BW'(a_re.err));
                            check("rsp_hold_stable", BW'(a_stable), BW'(1));
                        end
                        a_rsp_seen = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Loopback master and monitor for the zero-gap instance B
    // ------------------------------------------------------------------
    int            b_wait = 0, b_cyc = 0, b_last_evt = 0, b_starts = 0;
    bit            b_pending = 0, b_evt_valid = 0, b_done_q = 0, b_rise;
    logic [BW-1:0] b_exp;

    initial begin : master_b
        b_spi_done = 1'b0;
        b_spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_spi_done = 1'b0;
                b_wait     = 0;
            end else if (b_spi_start) begin
                b_spi_done = 1'b0;
                b_spi_rx   = b_spi_tx;
                b_wait     = 2;
            end else if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) b_spi_done = 1'b1;
            end
        end
    end

    initial begin : monitor_b
        forever begin
            @(negedge clk);
            #1;
            b_cyc++;
            b_rise   = b_spi_done && !b_done_q;
            b_done_q = b_spi_done;
            if (rst_n) begin
                if (b_spi_start) begin
                    if (b_evt_valid) check("gap0_spacing", BW'(b_cyc - b_last_evt), BW'(GAP_B + 1));
                    b_evt_valid = 1'b0;
                    b_pending   = 1'b1;
                    b_starts++;
                end else if (b_pending && b_rise) begin
                    b_pending   = 1'b0;
                    b_evt_valid = 1'b1;
                    b_last_evt  = b_cyc;
                end
                if (b_rsp_valid && b_rsp_ready) begin
                    check("gap0_rsp_expected", BW'(b_exp_q.size() > 0), BW'(1));
                    if (b_exp_q.size() > 0) begin
                        b_exp = b_exp_q.pop_front();
                        check("gap0_rsp_rx", b_rsp_rx, b_exp);
                        check("gap0_rsp_err", BW'(b_rsp_err), BW'(0));
                    end
                    b_evt_valid = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers for instance A
    // ------------------------------------------------------------------
    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pushes the expected bytes and response for one block and hands it to the DUT.
    task automatic issue_block(input logic [BW-1:0] tx, input bit loopback, input int hang,
                               input bit stale, input int hold);
        rsp_exp_t e;
        int       got;
        int       last;
        got  = (hang < 0) ? NB : hang;
        last = (hang < 0) ? NB - 1 : hang;
        for (int k = 0; k < NB; k++) begin
            m_rx_bytes[k] = loopback ? tx[BW-1-8*k -: 8] : 8'($urandom);
        end
        for (int k = 0; k <= last; k++) begin
            exp_tx_q.push_back('{data: tx[BW-1-8*k -: 8], idx: k});
        end
        e.rx  = model_rsp(m_rx_bytes, got);
        e.err = (hang >= 0);
        exp_rsp_q.push_back(e);
        m_hang    = hang;
        m_stale   = stale;
        m_k       = 0;
        rsp_ready = (hold == 0);
        @(negedge clk);
        blk_tx    = tx;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_tx    = rand_block();   // the DUT must have latched its own copy
        #1;
        check("accept_to_start", BW'(spi_start), BW'(1));
    endtask

    // Applies optional response backpressure, then waits for the response.
    task automatic finish_block(input int hold);
        int budget;
        if (hold > 0) begin
            // A block offered mid-transfer must be ignored.
            repeat (3) @(negedge clk);
            blk_valid = 1'b1;
            @(negedge clk);
            blk_valid = 1'b0;
            budget = 0;
            while (!rsp_valid && budget < 3000) begin
                @(negedge clk);
                budget++;
            end
            check("rsp_valid_arrives", BW'(rsp_valid), BW'(1));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                blk_valid = (i == hold / 2);
                #1;
                check("blk_ready_backpressure", BW'(blk_ready), BW'(0));
            end
            @(negedge clk);
            blk_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        budget = 0;
        while (exp_rsp_q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("rsp_delivered", BW'(exp_rsp_q.size() == 0), BW'(1));
        exp_rsp_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic send_block(input logic [BW-1:0] tx, input bit loopback, input int hang,
                              input bit stale, input int hold);
        issue_block(tx, loopback, hang, stale, hold);
        finish_block(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_ready"}, BW'(blk_ready), BW'(1));
        check({tag, "_busy"},      BW'(busy),      BW'(0));
        check({tag, "_spi_start"}, BW'(spi_start), BW'(0));
        check({tag, "_rsp_valid"}, BW'(rsp_valid), BW'(0));
        check({tag, "_rsp_err"},   BW'(rsp_err),   BW'(0));
        check({tag, "_byte_idx"},  BW'(byte_idx),  BW'(0));
        check({tag, "_spi_tx"},    BW'(spi_tx),    BW'(0));
        check({tag, "_rsp_rx"},    rsp_rx,         BW'(0));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int budget;
        int hang;
        logic [BW-1:0] btx;

        rst_n       = 1'b1;
        blk_valid   = 1'b0;
        blk_tx      = '0;
        rsp_ready   = 1'b1;
        b_blk_valid = 1'b0;
        b_blk_tx    = '0;
        b_rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;

        // Directed loopback block: bytes 0x00..0xFF in order, response equals the input.
        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, -1, 1'b0, 0);

        // Response backpressure for 20 cycles, with a block offered while busy.
        send_block(rand_block(), 1'b0, -1, 1'b0, 20);

        // Byte 5 never completes, so the timeout fires.
        send_block(rand_block(), 1'b0, 5, 1'b0, 0);

        // spi_done still high across each start.
        send_block(rand_block(), 1'b1, -1, 1'b1, 0);
        send_block(rand_block(), 1'b0, -1, 1'b1, 2);

        // Randomised mix.
        for (int n = 0; n < 8; n++) begin
            hang = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            send_block(rand_block(), 1'($urandom_range(0, 1)), hang,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a block.
        btx = rand_block();
        issue_block(btx, 1'b1, -1, 1'b0, 0);
        budget = 0;
        while (byte_idx != 4'd8 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("reach_byte8", BW'(byte_idx), BW'(8));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_block");
        exp_tx_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_block(rand_block(), 1'b1, -1, 1'b0, 0);
        send_block(rand_block(), 1'b0, -1, 1'b0, 0);

        // Zero-gap instance: two loopback blocks.
        for (int n = 0; n < 2; n++) begin
            btx = rand_block();
            b_exp_q.push_back(btx);
            @(negedge clk);
            b_blk_tx    = btx;
            b_blk_valid = 1'b1;
            @(negedge clk);
            b_blk_valid = 1'b0;
            budget = 0;
            while (b_exp_q.size() != 0 && budget < 3000) begin
                @(negedge clk);
                budget++;
            end
            check("gap0_rsp_delivered", BW'(b_exp_q.size() == 0), BW'(1));
        end
        check("gap0_start_count", BW'(b_starts), BW'(2 * NB));

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
